multi_debounce: RTL and testbench

//  N-channel button conditioner: synchronises, debounces and edge-detects raw buttons.

---
 rtl/multi_debounce.sv | 196 +++++++++++++++++++
 tb/tb_multi_debounce.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// N-channel button conditioner: 2-FF sync, debounce FSM, press/release pulses.
// Ports: CLK, RST (sync, active-high), BTN[N_CH] raw in; DB_LEVEL, PRESS,
//   REL_PULSE per channel; ANY_PRESS = OR of PRESS. Build option
//   MULTI_DEBOUNCE_REPEAT_EN adds auto-repeat PRESS while a button is held.
module multi_debounce #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 8,
  parameter int RISE_CLKS    = 25,
  parameter int FALL_CLKS    = 50,
  parameter int PULSE_CLKS   = 3,
  parameter int REPEAT_DELAY = 200,
  parameter int REPEAT_RATE  = 50
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BTN,
  output logic [N_CH-1:0] DB_LEVEL,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] REL_PULSE,
  output logic            ANY_PRESS
);

  typedef enum logic [2:0] {
    S_LOW, S_L2H, S_HIGH, S_H2L, S_PULSE
  } state_e;

  localparam int MAX_RF   = (RISE_CLKS > FALL_CLKS)
                          ? RISE_CLKS : FALL_CLKS;
  localparam int MAX_CLKS = (MAX_RF > PULSE_CLKS)
                          ? MAX_RF : PULSE_CLKS;

  localparam logic [CNT_W-1:0] RISE_C  = CNT_W'(RISE_CLKS);
  localparam logic [CNT_W-1:0] FALL_C  = CNT_W'(FALL_CLKS);
  localparam logic [CNT_W-1:0] PULS_M1 = CNT_W'(PULSE_CLKS - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  if (MAX_CLKS >= 2**CNT_W) begin : g_bad_cnt_w
    $error("CNT_W too narrow for *_CLKS");
  end
  if (PULSE_CLKS < 1) begin : g_bad_pulse
    $error("PULSE_CLKS must be >= 1");
  end

`ifdef MULTI_DEBOUNCE_REPEAT_EN
  localparam int RPT_W = CNT_W + 4;
  localparam logic [RPT_W-1:0] DLY_M1 = RPT_W'(REPEAT_DELAY - 1);
  // Reload after a repeat so the next hit lands REPEAT_RATE clocks later.
  localparam logic [RPT_W-1:0] RELOAD =
    RPT_W'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);
  if (REPEAT_RATE < 1 || REPEAT_DELAY < REPEAT_RATE ||
      REPEAT_DELAY >= 2**RPT_W) begin : g_bad_rpt
    $error("bad REPEAT_DELAY/REPEAT_RATE");
  end
`else
  if (REPEAT_DELAY < 0 || REPEAT_RATE < 0) begin : g_bad_rpt
    $error("REPEAT_* must be non-negative");
  end
`endif

  logic [N_CH-1:0] press_d;
  logic            any_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             lvl_q, lvl_d;
    logic             prs_q, prs_d;
    logic             rel_q, rel_d;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      prs_d = 1'b0;
      rel_d = rel_q;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
      rpt_d = rpt_q;
`endif
      case (st_q)
        S_LOW: begin
          if (s2_q) begin
            st_d  = S_L2H;
            cnt_d = ONE_C;
          end else begin
            cnt_d = '0;
          end
        end
        S_L2H: begin
          if (!s2_q) begin
            st_d  = S_LOW;
            cnt_d = '0;
          end else if (cnt_q == RISE_C) begin
            st_d  = S_HIGH;
            cnt_d = '0;
            lvl_d = 1'b1;
            prs_d = 1'b1;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
            rpt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        S_HIGH: begin
          if (!s2_q) begin
            st_d  = S_H2L;
            cnt_d = ONE_C;
          end
`ifdef MULTI_DEBOUNCE_REPEAT_EN
          else if (rpt_q == DLY_M1) begin
            prs_d = 1'b1;
            rpt_d = RELOAD;
          end else begin
            rpt_d = rpt_q + RPT_ONE;
          end
`endif
        end
        S_H2L: begin
          if (s2_q) begin
            st_d  = S_HIGH;
            cnt_d = '0;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
            rpt_d = '0;
`endif
          end else if (cnt_q == FALL_C) begin
            st_d  = S_PULSE;
            cnt_d = '0;
            lvl_d = 1'b0;
            rel_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        S_PULSE: begin
          if (cnt_q == PULS_M1) begin
            st_d  = S_LOW;
            cnt_d = '0;
            rel_d = 1'b0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        default: begin
          st_d  = S_LOW;
          cnt_d = '0;
          lvl_d = 1'b0;
          rel_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        st_q  <= S_LOW;
        cnt_q <= '0;
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
        rpt_q <= '0;
`endif
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        s1_q  <= BTN[i];
        s2_q  <= s1_q;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
        rpt_q <= rpt_d;
`endif
      end
    end

    assign press_d[i]   = prs_d;
    assign DB_LEVEL[i]  = lvl_q;
    assign PRESS[i]     = prs_q;
    assign REL_PULSE[i] = rel_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) any_q <= 1'b0;
    else     any_q <= |press_d;
  end

  assign ANY_PRESS = any_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce at default parameters.
// Covers reset, latency, bounce rejection, pulse widths, reset mid-pulse.
module tb_multi_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] db_level;
  logic [3:0] press;
  logic [3:0] rel_pulse;
  logic       any_press;

  int n_chk;
  int n_fail;

  multi_debounce dut (
    .CLK       (clk),
    .RST       (rst),
    .BTN       (btn),
    .DB_LEVEL  (db_level),
    .PRESS     (press),
    .REL_PULSE (rel_pulse),
    .ANY_PRESS (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; sample/drive 1 time unit after the last.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int np, pe, fall, rc, bad;
    int pe_q[$];
    int exp_q[$];
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    btn    = 4'hF;

    // 1: reset holds outputs low, then all channels press at edge 27
    step(3);
    chk("rst_db",  db_level,  0);
    chk("rst_prs", press,     0);
    chk("rst_rel", rel_pulse, 0);
    chk("rst_any", any_press, 0);
    rst = 1'b0;
    step(27);
    chk("t1_prs26", press,    0);
    chk("t1_db26",  db_level, 0);
    step(1);
    chk("t1_prs27", press,     4'hF);
    chk("t1_any27", any_press, 1);
    chk("t1_db27",  db_level,  4'hF);
    step(1);
    chk("t1_prs28", press,     0);
    chk("t1_any28", any_press, 0);
    chk("t1_db28",  db_level,  4'hF);
    btn = 4'h0;
    step(52);
    chk("t1_db51",  db_level,  4'hF);
    chk("t1_rel51", rel_pulse, 0);
    step(1);
    chk("t1_db52",  db_level,  0);
    chk("t1_rel52", rel_pulse, 4'hF);
    step(2);
    chk("t1_rel54", rel_pulse, 4'hF);
    step(1);
    chk("t1_rel55", rel_pulse, 0);
    step(5);

    // 2: bouncing input on ch1 never accepted
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      btn[1] = ((i / 10) % 2) == 0;
      step(1);
      if (press[1] || db_level[1] || any_press) bad++;
    end
    btn = 4'h0;
    step(60);
    chk("t2_bad", bad, 0);
    chk("t2_db",  db_level[1], 0);

    // 3: ch2 held 100 clks, then released
    np = 0;
    pe = -1;
    btn[2] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (press[2]) begin
        np++;
        if (pe < 0) pe = i;
      end
    end
    chk("t3_np",   np, 1);
    chk("t3_pe",   pe, 27);
    chk("t3_dbhi", db_level[2], 1);
    fall = -1;
    rc   = 0;
    np   = 0;
    btn[2] = 1'b0;
    for (int j = 0; j < 70; j++) begin
      step(1);
      if (!db_level[2] && fall < 0) fall = j;
      if (rel_pulse[2]) rc++;
      if (press[2]) np++;
    end
    chk("t3_fall", fall, 52);
    chk("t3_relw", rc,   3);
    chk("t3_np_r", np,   0);

    // 4: ch0 and ch3 rise together
    btn = 4'b1001;
    step(27);
    chk("t4_prs26", press, 0);
    step(1);
    chk("t4_prs27", press,     4'b1001);
    chk("t4_any27", any_press, 1);
    btn = 4'h0;
    step(70);

    // 5: reset in the middle of ch2 release pulse
    btn[2] = 1'b1;
    step(30);
    btn[2] = 1'b0;
    step(53);
    chk("t5_rel52", rel_pulse[2], 1);
    chk("t5_db52",  db_level[2],  0);
    step(1);
    chk("t5_rel53", rel_pulse[2], 1);
    rst = 1'b1;
    step(1);
    chk("t5_rel_r", rel_pulse[2], 0);
    chk("t5_db_r",  db_level,     0);
    rst = 1'b0;
    step(5);
    chk("t5_rel_n", rel_pulse, 0);
    btn[2] = 1'b1;
    step(27);
    chk("t5_prs26", press[2], 0);
    step(1);
    chk("t5_prs27", press[2], 1);
    btn = 4'h0;
    step(70);

    // 6: long hold on ch0; repeats only in the repeat build
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    exp_q = '{27, 227, 277, 327, 377};
`else
    exp_q = '{27};
`endif
    btn[0] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (press[0]) pe_q.push_back(i);
    end
    chk("t6_cnt", pe_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < pe_q.size())
        chk("t6_edge", pe_q[k], exp_q[k]);
    end
    btn = 4'h0;
    step(70);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
